// File: rtl/sq_step_ctrl.sv
// Step controller for the 19-bit CPU control unit: drives the sequence counter clear from the
// one-hot timing vector and sequences fetch/decode/execute/interrupt/halt phases.
module sq_step_ctrl #(
  parameter int unsigned         OP_W   = 5,
  parameter logic [OP_W-1:0]     HLT_OP = 5'h1F,
  parameter int unsigned         MAX_EX = 13
) (
  input  logic            CLK,
  input  logic            CLR_N,
  input  logic [15:0]     T,
  input  logic [OP_W-1:0] OPCODE,
  input  logic [3:0]      EXEC_LEN,
  input  logic            INT_REQ,
  input  logic            IEN,
  input  logic            RESUME,
  output logic            SC_CLR,
  output logic            FETCH_EN,
  output logic            DECODE_EN,
  output logic            EXEC_EN,
  output logic [3:0]      EXEC_STEP,
  output logic            INT_ACK,
  output logic            HALTED,
  output logic            T_ERR
);

  localparam logic [3:0] MaxEx = 4'(MAX_EX);

  typedef enum logic [2:0] {StSync, StFetch, StExec, StIntr, StHalt} state_e;

  state_e     state_q, state_d;
  logic [3:0] exp_step_q, exp_step_d;
  logic [3:0] lat_len_q, lat_len_d;
  logic       t_err_q;
  logic       wrap_q, wrap_d;
  logic       t_onehot;
  logic       step_err;
  logic [3:0] len_clamped;

  always_comb begin
    t_onehot = (T != 16'd0) && ((T & (T - 16'd1)) == 16'd0);
    // wrap_q catches a 15->0 roll that would otherwise look like a legal T0
    step_err = (state_q != StSync) && (!t_onehot || !T[exp_step_q] || wrap_q);
    if (EXEC_LEN == 4'd0) begin
      len_clamped = 4'd1;
    end else if (EXEC_LEN > MaxEx) begin
      len_clamped = MaxEx;
    end else begin
      len_clamped = EXEC_LEN;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_len_d = lat_len_q;
    SC_CLR    = 1'b0;
    FETCH_EN  = 1'b0;
    DECODE_EN = 1'b0;
    EXEC_EN   = 1'b0;
    EXEC_STEP = 4'd0;
    INT_ACK   = 1'b0;
    HALTED    = 1'b0;
    if (step_err) begin
      SC_CLR  = 1'b1;
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StSync: begin
          SC_CLR  = 1'b1;
          state_d = StFetch;
        end
        StFetch: begin
          if (exp_step_q < 4'd2) begin
            FETCH_EN = 1'b1;
          end else if (exp_step_q == 4'd2) begin
            DECODE_EN = 1'b1;
            lat_len_d = len_clamped;
            if (OPCODE == HLT_OP) begin
              SC_CLR  = 1'b1;
              state_d = StHalt;
            end else begin
              state_d = StExec;
            end
          end
        end
        StExec: begin
          EXEC_EN   = 1'b1;
          EXEC_STEP = exp_step_q - 4'd3;
          if ({1'b0, exp_step_q} == 5'd2 + {1'b0, lat_len_q}) begin
            SC_CLR  = 1'b1;
            state_d = (INT_REQ && IEN) ? StIntr : StFetch;
          end
        end
        StIntr: begin
          INT_ACK = (exp_step_q == 4'd0);
          if (exp_step_q == 4'd2) begin
            SC_CLR  = 1'b1;
            state_d = StFetch;
          end
        end
        StHalt: begin
          // Clear stays high on the resume cycle so FETCH starts on a parked T0
          HALTED = 1'b1;
          SC_CLR = 1'b1;
          if (RESUME) state_d = StFetch;
        end
        default: begin
          SC_CLR  = 1'b1;
          state_d = StSync;
        end
      endcase
    end
    exp_step_d = SC_CLR ? 4'd0 : exp_step_q + 4'd1;
    wrap_d     = !SC_CLR && (exp_step_q == 4'hF);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q    <= StSync;
      exp_step_q <= 4'd0;
      lat_len_q  <= 4'd1;
      t_err_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_step_q <= exp_step_d;
      lat_len_q  <= lat_len_d;
      t_err_q    <= t_err_q | step_err;
      wrap_q     <= wrap_d;
    end
  end

  assign T_ERR = t_err_q;

endmodule

// File: tb/tb_sq_step_ctrl.sv
// Bench for sq_step_ctrl: models the sequence counter, builds the expected per-cycle strobe
// trace from instruction-level rules, and checks it through a scoreboard queue.
module tb_sq_step_ctrl;

  localparam logic [4:0] HLT = 5'h1F;
  localparam int unsigned MAXEX = 13;

  logic        CLK = 1'b0;
  logic        CLR_N;
  logic [15:0] T;
  logic [4:0]  OPCODE;
  logic [3:0]  EXEC_LEN;
  logic        INT_REQ, IEN, RESUME;
  logic        SC_CLR, FETCH_EN, DECODE_EN, EXEC_EN, INT_ACK, HALTED, T_ERR;
  logic [3:0]  EXEC_STEP;

  logic [3:0]  cnt;
  logic        force_en;
  logic [15:0] force_val;
  logic        terr;

  // {sc_clr, fetch, decode, exec_en, step[3:0], int_ack, halted, t_err}
  logic [10:0] exq[$];
  string       nmq[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  sq_step_ctrl #(.OP_W(5), .HLT_OP(HLT), .MAX_EX(MAXEX)) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .T         (T),
    .OPCODE    (OPCODE),
    .EXEC_LEN  (EXEC_LEN),
    .INT_REQ   (INT_REQ),
    .IEN       (IEN),
    .RESUME    (RESUME),
    .SC_CLR    (SC_CLR),
    .FETCH_EN  (FETCH_EN),
    .DECODE_EN (DECODE_EN),
    .EXEC_EN   (EXEC_EN),
    .EXEC_STEP (EXEC_STEP),
    .INT_ACK   (INT_ACK),
    .HALTED    (HALTED),
    .T_ERR     (T_ERR)
  );

  always #5 CLK = ~CLK;

  // Sequence counter model: +1 per clock, cleared by SC_CLR
  always @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) cnt <= 4'd0;
    else        cnt <= SC_CLR ? 4'd0 : cnt + 4'd1;
  end

  assign T = force_en ? force_val : (16'd1 << cnt);

  // Monitor: every cycle the DUT presents its strobes, compare against the queued expectation
  always @(negedge CLK) begin
    if (exq.size() > 0) begin
      logic [10:0] e, a;
      string       nm;
      e  = exq.pop_front();
      nm = nmq.pop_front();
      a  = {SC_CLR, FETCH_EN, DECODE_EN, EXEC_EN, EXEC_STEP, INT_ACK, HALTED, T_ERR};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: actual=%b required=%b (sc,fetch,decode,exec,step4,ack,halt,terr)",
                 nm, $time, a, e);
      end
    end
  end

  function automatic logic [10:0] mk(input logic sc, input logic f, input logic d,
                                     input logic x, input logic [3:0] st, input logic ack,
                                     input logic h);
    return {sc, f, d, x, st, ack, h, terr};
  endfunction

  task automatic cyc(input logic [10:0] e, input string nm);
    exq.push_back(e);
    nmq.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  // One instruction from T0; err_k / rst_k inject a bad T or a reset at that exec step
  task automatic run_instr(input logic [4:0] op, input logic [3:0] len, input logic ireq,
                           input logic ien, input int hold_n, input int err_k,
                           input logic [15:0] err_val, input int rst_k);
    int eff;
    OPCODE   = op;
    EXEC_LEN = len;
    INT_REQ  = ireq;
    IEN      = ien;
    RESUME   = 1'b0;
    cyc(mk(0, 1, 0, 0, 4'd0, 0, 0), "fetch_t0");
    cyc(mk(0, 1, 0, 0, 4'd0, 0, 0), "fetch_t1");
    if (op == HLT) begin
      cyc(mk(1, 0, 1, 0, 4'd0, 0, 0), "decode_hlt");
      for (int i = 0; i < hold_n; i++) cyc(mk(1, 0, 0, 0, 4'd0, 0, 1), "halt_hold");
      RESUME = 1'b1;
      cyc(mk(1, 0, 0, 0, 4'd0, 0, 1), "halt_resume");
      RESUME = 1'b0;
      return;
    end
    cyc(mk(0, 0, 1, 0, 4'd0, 0, 0), "decode");
    // Decoder inputs are only valid at T2; scramble them to prove they were latched
    OPCODE   = 5'($urandom_range(0, 30));
    EXEC_LEN = 4'($urandom_range(0, 15));
    eff = (len == 0) ? 1 : ((len > MAXEX) ? MAXEX : int'(len));
    for (int k = 0; k < eff; k++) begin
      if (k == rst_k) begin
        CLR_N = 1'b0;
        terr  = 1'b0;
        cyc(mk(1, 0, 0, 0, 4'd0, 0, 0), "reset_mid_exec");
        cyc(mk(1, 0, 0, 0, 4'd0, 0, 0), "reset_hold");
        CLR_N = 1'b1;
        cyc(mk(1, 0, 0, 0, 4'd0, 0, 0), "sync");
        return;
      end
      if (k == err_k) begin
        force_en  = 1'b1;
        force_val = err_val;
        cyc(mk(1, 0, 0, 0, 4'd0, 0, 0), "step_err");
        force_en  = 1'b0;
        terr      = 1'b1;
        return;
      end
      cyc(mk(k == eff - 1, 0, 0, 1, 4'(k), 0, 0), (k == eff - 1) ? "exec_last" : "exec");
    end
    if (ireq && ien) begin
      cyc(mk(0, 0, 0, 0, 4'd0, 1, 0), "intr_ack");
      cyc(mk(0, 0, 0, 0, 4'd0, 0, 0), "intr_t1");
      cyc(mk(1, 0, 0, 0, 4'd0, 0, 0), "intr_t2");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    CLR_N     = 1'b0;
    OPCODE    = 5'd0;
    EXEC_LEN  = 4'd0;
    INT_REQ   = 1'b0;
    IEN       = 1'b0;
    RESUME    = 1'b0;
    force_en  = 1'b0;
    force_val = 16'd0;
    terr      = 1'b0;
    @(posedge CLK);
    #1;
    cyc(mk(1, 0, 0, 0, 4'd0, 0, 0), "reset");
    cyc(mk(1, 0, 0, 0, 4'd0, 0, 0), "reset");
    CLR_N = 1'b1;
    cyc(mk(1, 0, 0, 0, 4'd0, 0, 0), "sync");

    run_instr(5'h03, 4'd2, 0, 0, 0, -1, 16'd0, -1);
    run_instr(5'h03, 4'd2, 0, 0, 0, -1, 16'd0, -1);
    run_instr(5'h04, 4'd0, 0, 0, 0, -1, 16'd0, -1);
    run_instr(5'h05, 4'd15, 0, 0, 0, -1, 16'd0, -1);
    run_instr(5'h06, 4'd2, 1, 1, 0, -1, 16'd0, -1);
    run_instr(5'h07, 4'd2, 1, 0, 0, -1, 16'd0, -1);
    run_instr(HLT, 4'd3, 1, 1, 10, -1, 16'd0, -1);
    run_instr(5'h08, 4'd3, 0, 0, 0, 0, 16'h0003, -1);
    run_instr(5'h09, 4'd1, 0, 0, 0, -1, 16'd0, -1);
    run_instr(5'h0A, 4'd3, 0, 0, 0, 1, 16'h0020, -1);
    run_instr(5'h0B, 4'd2, 1, 1, 0, -1, 16'd0, -1);
    run_instr(5'h0C, 4'd5, 0, 0, 0, -1, 16'd0, 2);
    run_instr(5'h0D, 4'd13, 0, 0, 0, -1, 16'd0, -1);

    for (int n = 0; n < 80; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 7) == 0) ? HLT : 5'($urandom_range(0, 30));
      run_instr(op, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                $urandom_range(0, 4), -1, 16'd0, -1);
    end

    repeat (2) @(negedge CLK);
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
